// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator front end and controller.
package elevator_pkg;

  // Floor count is fixed at 8 in this release: req bit 0 = G, bit 7 = F7.
  localparam int unsigned NUM_FLOORS       = 8;
  localparam int unsigned DEBOUNCE_CYC_DEF = 16;

  // Floor codes, shared with the controller's pfloor encoding.
  typedef enum logic [2:0] {
    FLR_G  = 3'd0,
    FLR_F1 = 3'd1,
    FLR_F2 = 3'd2,
    FLR_F3 = 3'd3,
    FLR_F4 = 3'd4,
    FLR_F5 = 3'd5,
    FLR_F6 = 3'd6,
    FLR_F7 = 3'd7
  } floor_e;

  // One-hot request mask for a floor code.
  function automatic logic [NUM_FLOORS-1:0] floor_onehot(input floor_e f);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    m[f] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One raw button: 2-flop synchroniser followed by a stable-count debouncer.
// The debounced level only moves after DEBOUNCE_CYC consecutive cycles of
// disagreement between the synchronised input and the current level.
module button_debounce
  #(
    parameter int unsigned DEBOUNCE_CYC = 16
  )
  (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic deb_o
  );

  localparam int unsigned CW = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          deb_q, deb_d;

  // Synchroniser and debounce state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      deb_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
    end
  end

  // Count disagreement cycles; accept the new level on the last one.
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (sync_q[1] == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      deb_d = sync_q[1];
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/call_request_latch.sv
// Elevator front end: debounces floor and door buttons and latches each
// debounced floor press as a pending request until the car serves that floor.
module call_request_latch
  import elevator_pkg::*;
  #(
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
  )
  (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] btn_floor,
    input  logic                  btn_open,
    input  logic                  btn_close,
    input  logic                  door_open,
    input  logic [2:0]            cur_floor,
    output logic [NUM_FLOORS-1:0] req,
    output logic                  req_any,
    output logic                  open_req,
    output logic                  close_req
  );

  logic [NUM_FLOORS-1:0] deb_floor;
  logic [NUM_FLOORS-1:0] deb_d1_q;
  logic [NUM_FLOORS-1:0] req_q, req_d;
  logic [NUM_FLOORS-1:0] rise;
  logic [NUM_FLOORS-1:0] clr;
  logic                  deb_open, deb_close;

  for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_floor
    button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk   (clk),
      .rst   (rst),
      .btn_i (btn_floor[i]),
      .deb_o (deb_floor[i])
    );
  end

  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_open (
    .clk   (clk),
    .rst   (rst),
    .btn_i (btn_open),
    .deb_o (deb_open)
  );

  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_close (
    .clk   (clk),
    .rst   (rst),
    .btn_i (btn_close),
    .deb_o (deb_close)
  );

  // Delayed debounced levels for edge detection, and the request register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_d1_q <= '0;
      req_q    <= '0;
    end else begin
      deb_d1_q <= deb_floor;
      req_q    <= req_d;
    end
  end

  // Set on a debounced rising edge; clearing the served floor wins over a set.
  always_comb begin
    rise  = deb_floor & ~deb_d1_q;
    clr   = door_open ? floor_onehot(floor_e'(cur_floor)) : '0;
    req_d = (req_q | rise) & ~clr;
  end

  assign req       = req_q;
  assign req_any   = |req_q;
  assign open_req  = deb_open;
  assign close_req = deb_close;

endmodule
